// File: rtl/lane_writer_if.sv
// Lane-side push bus and single-word memory write port of the lane writer.
// The DUT uses the slave modport; the producer/memory side uses master.
interface lane_writer_if #(
  parameter int LANES  = 12,
  parameter int DATA_W = 8,
  parameter int OFF_W  = 6
);
  logic [LANES-1:0]        write;
  logic [LANES*DATA_W-1:0] in;
  logic [LANES-1:0]        full;
  logic                    idle;
  logic                    mem_we;
  logic [4+OFF_W-1:0]      mem_addr;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_ready;

  modport master (
    output write, in, mem_ready,
    input  full, idle, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  write, in, mem_ready,
    output full, idle, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/lane_writer.sv
// Per-lane result FIFOs drained round-robin onto one memory write port,
// each lane writing its own region at an auto-incrementing offset.
module lane_writer #(
  parameter int LANES  = 12,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int OFF_W  = 6
) (
  input  logic         clk,
  input  logic         rst,
  lane_writer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = 4;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_reg, state_next;
  logic [LW-1:0]         rr_reg;
  logic [4+OFF_W-1:0]    addr_reg;
  logic [DATA_W-1:0]     data_reg;

  logic [LANES-1:0]      nonempty, push, pop;
  logic [DATA_W-1:0]     head [LANES];
  logic [OFF_W-1:0]      off_cur [LANES];
  logic                  grant_valid;
  logic [LW-1:0]         grant, rr_next, cur_lane;
  logic [LW:0]           cand;
  logic [OFF_W-1:0]      off_sel;
  logic                  load, xfer;

  assign cur_lane = addr_reg[4+OFF_W-1 -: LW];

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [PW-1:0]     wr_ptr_reg, rd_ptr_reg;
      logic [CW-1:0]     count_reg;
      logic [OFF_W-1:0]  off_reg;
      logic [DATA_W-1:0] mem_reg [DEPTH];

      assign nonempty[gi] = (count_reg != '0);
      assign bus.full[gi] = (count_reg == CW'(DEPTH));
      assign push[gi]     = bus.write[gi] && !bus.full[gi];
      assign pop[gi]      = load && (grant == LW'(gi));
      assign head[gi]     = mem_reg[rd_ptr_reg];
      assign off_cur[gi]  = off_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
          off_reg    <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
          count_reg <= count_reg + CW'(push[gi]) - CW'(pop[gi]);
          if (xfer && (cur_lane == LW'(gi))) off_reg <= off_reg + 1'b1;
        end
      end

      // Storage is not reset; occupancy alone decides what is valid.
      always_ff @(posedge clk) begin
        if (push[gi]) mem_reg[wr_ptr_reg] <= bus.in[gi*DATA_W +: DATA_W];
      end
    end
  endgenerate

  // First non-empty lane at or after rr; descending scan leaves the closest.
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    cand        = '0;
    for (int k = LANES - 1; k >= 0; k--) begin
      cand = {1'b0, rr_reg} + (LW+1)'(k);
      if (cand >= (LW+1)'(LANES)) cand = cand - (LW+1)'(LANES);
      if (nonempty[cand[LW-1:0]]) begin
        grant_valid = 1'b1;
        grant       = cand[LW-1:0];
      end
    end
  end

  assign rr_next = (grant == LW'(LANES - 1)) ? '0 : grant + 1'b1;
  // A back-to-back grant to the lane just transferred must see its bumped offset.
  assign off_sel = off_cur[grant] + OFF_W'(xfer && (cur_lane == grant));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_valid) state_next = ISSUE;
      ISSUE:   if (bus.mem_ready && !grant_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    xfer         = (state_reg == ISSUE) && bus.mem_ready;
    load         = grant_valid && ((state_reg == IDLE) || bus.mem_ready);
    bus.mem_we   = (state_reg == ISSUE);
    bus.idle     = (state_reg == IDLE) && !(|nonempty);
    bus.mem_addr = addr_reg;
    bus.mem_data = data_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg <= '0;
      data_reg <= '0;
      rr_reg   <= '0;
    end else if (load) begin
      addr_reg <= {grant, off_sel};
      data_reg <= head[grant];
      rr_reg   <= rr_next;
    end
  end
endmodule

// File: doc/lane_writer.md
# lane_writer

Write-back engine for the sparse accelerator datapath, and the mirror of the fetcher. The fetcher streams memory words out to 12 lanes through per-lane FIFOs. This block accepts 8-bit results from the same 12 lanes into per-lane FIFOs. It drains them round-robin onto a single-word memory write port, using a private address region and an auto-incrementing offset per lane.

## Interface
- LANES, 12, number of lanes (max 16)
- DATA_W, 8, data width per lane word
- DEPTH, 4, entries per lane FIFO (power of 2, ≥2)
- OFF_W, 6, per-lane offset width; lane region holds 2^OFF_W words

- clk  in  1  clock, all state changes on the rising edge
- rst  in  1  asynchronous reset, active-low
- write  in  LANES  per-lane push strobe; bit i pushes lane i
- in  in  LANES*DATA_W  lane data; lane i at bits [i*DATA_W +: DATA_W]
- full  out  LANES  lane FIFO holds DEPTH entries
- idle  out  1  all FIFOs empty and no memory write pending
- mem_we  out  1  memory write request
- mem_addr  out  4+OFF_W  {lane index[3:0], lane offset}
- mem_data  out  DATA_W  write data
- mem_ready  in  1  memory accepts; transfer happens on an edge where mem_we && mem_ready

## Operation
- Per-lane FIFO
  - A push happens when write[i] && !full[i].
  - A write while full is dropped; FIFO contents are unchanged.
  - full is registered state, evaluated before the edge. A push into a full lane is dropped even if a pop occurs on the same edge.
  - Push and pop on the same edge of a non-full, non-empty lane leaves the count unchanged.
- Per-lane offset counter off[i]
  - Resets to 0.
  - Increments on each completed memory transfer from lane i.
  - Wraps from 2^OFF_W-1 to 0 silently.
- Round-robin pointer rr
  - Resets to 0.
  - Grant goes to the first non-empty lane at or after rr, wrapping at LANES-1 → 0.
  - After a grant to lane g, rr becomes g+1 mod LANES.
- State machine
  - IDLE: if any lane is non-empty, grant, pop that FIFO, and load mem_addr={g,off[g]} and mem_data=head. mem_we goes 1 and the state moves to ISSUE. Otherwise stay in IDLE with mem_we=0.
  - ISSUE: mem_we, mem_addr and mem_data are held stable until mem_ready=1 at an edge.
    - On that edge, off[g] increments.
    - If another lane is non-empty (evaluated with pre-edge FIFO state, with the pointer already advanced), grant, pop and load it; stay in ISSUE.
    - Otherwise drop mem_we and go to IDLE.
- idle = (state==IDLE) && all FIFOs empty. It is combinational from registers.
- Reset mid-operation: all FIFOs are emptied, counters and rr are cleared, state goes to IDLE, and mem_we drops immediately (async). An in-flight word is discarded.

## Timing
- Reset values:
  - full=0
  - idle=1
  - mem_we=0
  - mem_addr=0
  - mem_data=0
  - state=IDLE
- Latency: a push at edge N (lane empty, writer IDLE) gives mem_we=1 with that word after edge N+1.
- Throughput: with mem_ready held 1 and data queued, one word per cycle. mem_we stays high continuously.
- mem_ready=0 stalls indefinitely. FIFOs keep accepting until full.
- A word pushed on the same edge the arbiter evaluates is not visible until the next edge.
- mem_addr and mem_data change only on a transfer edge or on an IDLE→ISSUE edge.

## Test plan
- Reset, then single word: rst low 3 cycles, then high; mem_ready=1; push lane 3 with 0xA5 at edge N.
  - mem_we=1, mem_addr=0x0C0, mem_data=0xA5 after edge N+1.
  - mem_we=0 and idle=1 after edge N+2.
- Round-robin: push lanes 0, 5 and 11 simultaneously with 0x10, 0x50, 0xB0; mem_ready=1.
  - Three consecutive transfers: addr 0x000/0x10, 0x140/0x50, 0x2C0/0xB0.
  - Then push lane 0 again; it goes to 0x001.
- Backpressure and full: mem_ready=0; push lane 1 six times with values 1..6.
  - The first value goes to the output register, and full[1]=1 after four more.
  - The sixth push is dropped.
  - Release mem_ready; addresses 0x040..0x044 receive 1..5, and 6 is never written.
- Offset wrap: push 65 words into lane 2, keeping it below full.
  - Writes go to offsets 0..63, then offset 0 again (mem_addr=0x080) with the 65th word.
- Stall hold: mem_ready toggles 0,0,1. mem_addr and mem_data stay constant across the stalled cycles, and exactly one transfer completes.
- Async reset mid-burst: assert rst low between edges while mem_we=1 with lanes queued.
  - mem_we=0 and full=0 immediately.
  - After release, idle=1 and the next push to lane 0 writes address 0x000.
